bram_stream_loader: RTL and testbench

BRAM_STREAM_LOADER -- requirements
Module: bram_stream_loader

---
 rtl/bram_stream_loader.sv | 195 +++++++++++++++++++
 tb/tb_bram_stream_loader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_loader.sv
// Packs a narrow element stream into memory words and either writes them to a BRAM
// port (load) or reads them back and compares the filled lanes (verify).
module bram_stream_loader #(
  parameter int DATA_WIDTH = 40,
  parameter int LANE_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic                  abort_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [LANE_WIDTH-1:0] s_data_i,
  input  logic                  s_last_i,
  output logic                  mem_we_o,
  output logic                  mem_re_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [ADDR_WIDTH-1:0] mismatch_addr_o,
  output logic [ADDR_WIDTH:0]   words_o,
  output logic [ADDR_WIDTH-1:0] end_addr_o
);

  localparam int LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int LCW   = $clog2(LANES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_WRITE, S_RD_REQ, S_RD_WAIT, S_CMP, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  mode_q, mode_d;
  logic                  last_q, last_d;
  logic [LCW-1:0]        lane_q, lane_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;
  logic                  error_q, error_d;
  logic [ADDR_WIDTH-1:0] mm_addr_q, mm_addr_d;
  logic [ADDR_WIDTH-1:0] end_addr_q, end_addr_d;
  logic                  advance;
  logic                  mism;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    last_d     = last_q;
    lane_d     = lane_q;
    word_d     = word_q;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    words_d    = words_q;
    error_d    = error_q;
    mm_addr_d  = mm_addr_q;
    end_addr_d = end_addr_q;
    s_ready_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_re_o   = 1'b0;
    done_o     = 1'b0;
    advance    = 1'b0;
    mism       = 1'b0;

    // lane_q equals the number of filled lanes once a word has completed
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(lane_q) &&
          rdata_q[i*LANE_WIDTH +: LANE_WIDTH] != word_q[i*LANE_WIDTH +: LANE_WIDTH])
        mism = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_FILL;
          mode_d    = mode_i;
          addr_d    = base_addr_i;
          lane_d    = '0;
          word_d    = '0;
          words_d   = '0;
          error_d   = 1'b0;
          mm_addr_d = '0;
        end
      end
      S_FILL: begin
        s_ready_o = 1'b1;
        if (s_valid_i) begin
          word_d[int'(lane_q)*LANE_WIDTH +: LANE_WIDTH] = s_data_i;
          lane_d = lane_q + LCW'(1);
          if (lane_q == LCW'(LANES - 1) || s_last_i) begin
            last_d  = s_last_i;
            state_d = mode_q ? S_RD_REQ : S_WRITE;
          end
        end
      end
      S_WRITE: begin
        mem_we_o = 1'b1;
        advance  = 1'b1;
      end
      S_RD_REQ: begin
        mem_re_o = 1'b1;
        state_d  = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        rdata_d = mem_rdata_i;
        state_d = S_CMP;
      end
      S_CMP: begin
        advance = 1'b1;
        if (mism) begin
          error_d = 1'b1;
          if (!error_q) mm_addr_d = addr_q;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      addr_d  = addr_q + ADDR_WIDTH'(1);
      words_d = words_q + (ADDR_WIDTH+1)'(1);
      lane_d  = '0;
      word_d  = '0;
      if (last_q) begin
        state_d    = S_DONE;
        end_addr_d = addr_q + ADDR_WIDTH'(1);
      end else begin
        state_d = S_FILL;
      end
    end

    // Abort wins over everything in flight: drop the partial word and keep only
    // the results of words that already finished.
    if (abort_i && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      lane_d     = '0;
      word_d     = '0;
      addr_d     = addr_q;
      words_d    = words_q;
      error_d    = error_q;
      mm_addr_d  = mm_addr_q;
      end_addr_d = end_addr_q;
      s_ready_o  = 1'b0;
      mem_we_o   = 1'b0;
      mem_re_o   = 1'b0;
      done_o     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      last_q     <= 1'b0;
      lane_q     <= '0;
      word_q     <= '0;
      rdata_q    <= '0;
      addr_q     <= '0;
      words_q    <= '0;
      error_q    <= 1'b0;
      mm_addr_q  <= '0;
      end_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      last_q     <= last_d;
      lane_q     <= lane_d;
      word_q     <= word_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
      error_q    <= error_d;
      mm_addr_q  <= mm_addr_d;
      end_addr_q <= end_addr_d;
    end
  end

  assign mem_addr_o      = addr_q;
  assign mem_wdata_o     = word_q;
  assign busy_o          = (state_q != S_IDLE);
  assign error_o         = error_q;
  assign mismatch_addr_o = mm_addr_q;
  assign words_o         = words_q;
  assign end_addr_o      = end_addr_q;

endmodule

// File: tb/tb_bram_stream_loader.sv
// Self-checking bench for bram_stream_loader: session table with a strobe scoreboard,
// plus abort/reset sequences and a 20-bit-lane instance.
module tb_bram_stream_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, mode_i, abort_i, s_valid_i, s_last_i;
  logic [15:0] base_addr_i;
  logic [7:0]  s_data_i;
  logic        s_ready_o, mem_we_o, mem_re_o, busy_o, done_o, error_o;
  logic [15:0] mem_addr_o, mismatch_addr_o, end_addr_o;
  logic [39:0] mem_wdata_o, mem_rdata_i;
  logic [16:0] words_o;

  // second instance with 20-bit lanes
  logic        b_start, b_abort, b_valid, b_last;
  logic [19:0] b_data;
  logic        b_ready, b_we, b_re, b_busy, b_done, b_error;
  logic [15:0] b_addr, b_mm, b_end;
  logic [39:0] b_wdata;
  logic [16:0] b_words;

  always #5 clk = ~clk;

  bram_stream_loader u_dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i),
    .base_addr_i(base_addr_i), .abort_i(abort_i), .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_last_i(s_last_i),
    .mem_we_o(mem_we_o), .mem_re_o(mem_re_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o),
    .done_o(done_o), .error_o(error_o), .mismatch_addr_o(mismatch_addr_o),
    .words_o(words_o), .end_addr_o(end_addr_o)
  );

  bram_stream_loader #(.DATA_WIDTH(40), .LANE_WIDTH(20), .ADDR_WIDTH(16)) u_dut20 (
    .clk(clk), .rst_n(rst_n), .start_i(b_start), .mode_i(1'b0),
    .base_addr_i(16'h0000), .abort_i(b_abort), .s_valid_i(b_valid),
    .s_ready_o(b_ready), .s_data_i(b_data), .s_last_i(b_last),
    .mem_we_o(b_we), .mem_re_o(b_re), .mem_addr_o(b_addr),
    .mem_wdata_o(b_wdata), .mem_rdata_i(40'h0), .busy_o(b_busy),
    .done_o(b_done), .error_o(b_error), .mismatch_addr_o(b_mm),
    .words_o(b_words), .end_addr_o(b_end)
  );

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int b_we_cnt = 0;
  logic [15:0] b_we_addr;
  logic [39:0] b_we_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // BRAM model: write and read both take effect at the clock edge, read data follows one cycle later
  logic [39:0] mem [0:65535];
  logic        poke_en;
  logic [15:0] poke_addr;
  logic [39:0] poke_data;
  always @(posedge clk) begin
    if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
    if (mem_re_o) mem_rdata_i <= mem[mem_addr_o];
    if (poke_en)  mem[poke_addr] <= poke_data;
  end

  typedef struct {
    logic        rd;
    logic [15:0] addr;
    logic [39:0] data;
  } exp_t;
  exp_t sbq[$];

  always @(negedge clk) begin
    if (mem_we_o || mem_re_o) begin
      exp_t e;
      chk("we_re_exclusive", {63'b0, mem_we_o & mem_re_o}, 64'd0);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: we=%0b re=%0b addr=%0h, none expected", mem_we_o, mem_re_o, mem_addr_o);
      end else begin
        e = sbq.pop_front();
        chk("strobe_kind", {63'b0, mem_re_o}, {63'b0, e.rd});
        chk("strobe_addr", {48'b0, mem_addr_o}, {48'b0, e.addr});
        if (!e.rd) chk("write_data", {24'b0, mem_wdata_o}, {24'b0, e.data});
      end
    end
    if (done_o) done_cnt++;
    if (b_we) begin
      b_we_cnt++;
      b_we_addr = b_addr;
      b_we_data = b_wdata;
    end
  end

  typedef struct {
    logic        mode;
    logic [15:0] base;
    int          n;
    logic [7:0]  d0;
    logic        exp_err;
    logic [15:0] exp_mm;
    logic [16:0] exp_words;
    logic [15:0] exp_end;
  } vec_t;
  vec_t vecs [6];

  task automatic send_elem(input logic [7:0] d, input logic last);
    int t = 0;
    s_valid_i = 1'b1;
    s_data_i  = d;
    s_last_i  = last;
    while (!s_ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL s_ready_timeout: got ready=0 for 50 cycles, required ready=1");
    end
    @(posedge clk);
    @(negedge clk);
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic start_session(input logic m, input logic [15:0] base);
    start_i     = 1'b1;
    mode_i      = m;
    base_addr_i = base;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic run_session(input vec_t v);
    logic [39:0] word = '0;
    logic [15:0] addr = v.base;
    int lane = 0;
    int done0 = done_cnt;
    int t = 0;
    exp_t e;
    for (int k = 0; k < v.n; k++) begin
      word = word | (40'(8'(v.d0 + 8'(k))) << (8 * lane));
      lane++;
      if (lane == 5 || k == v.n - 1) begin
        e.rd = v.mode;
        e.addr = addr;
        e.data = word;
        sbq.push_back(e);
        addr = addr + 16'd1;
        word = '0;
        lane = 0;
      end
    end
    start_session(v.mode, v.base);
    for (int k = 0; k < v.n; k++) send_elem(8'(v.d0 + 8'(k)), (k == v.n - 1));
    while (!done_o && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk("done_pulse", {63'b0, done_o}, 64'd1);
    chk("words_o", {47'b0, words_o}, {47'b0, v.exp_words});
    chk("end_addr_o", {48'b0, end_addr_o}, {48'b0, v.exp_end});
    chk("error_o", {63'b0, error_o}, {63'b0, v.exp_err});
    chk("mismatch_addr_o", {48'b0, mismatch_addr_o}, {48'b0, v.exp_mm});
    @(negedge clk);
    chk("idle_after_done", {63'b0, busy_o}, 64'd0);
    chk("done_count", 64'(done_cnt - done0), 64'd1);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    int t;
    int done0;
    vecs[0] = '{1'b0, 16'h0010, 7,  8'h01, 1'b0, 16'h0000, 17'd2, 16'h0012};
    vecs[1] = '{1'b1, 16'h0010, 7,  8'h01, 1'b0, 16'h0000, 17'd2, 16'h0012};
    vecs[2] = '{1'b1, 16'h0010, 7,  8'h01, 1'b1, 16'h0011, 17'd2, 16'h0012};
    vecs[3] = '{1'b0, 16'hFFFF, 10, 8'h20, 1'b0, 16'h0000, 17'd2, 16'h0001};
    vecs[4] = '{1'b1, 16'hFFFF, 10, 8'h20, 1'b0, 16'h0000, 17'd2, 16'h0001};
    vecs[5] = '{1'b0, 16'h0100, 1,  8'h55, 1'b0, 16'h0000, 17'd1, 16'h0101};

    rst_n = 1'b0;
    start_i = 0; mode_i = 0; base_addr_i = '0; abort_i = 0;
    s_valid_i = 0; s_last_i = 0; s_data_i = '0;
    b_start = 0; b_abort = 0; b_valid = 0; b_last = 0; b_data = '0;
    poke_en = 0; poke_addr = '0; poke_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {63'b0, s_ready_o}, 64'd0);
    chk("rst_busy", {63'b0, busy_o}, 64'd0);
    chk("rst_strobes", {62'b0, mem_we_o, mem_re_o}, 64'd0);
    chk("rst_words", {47'b0, words_o}, 64'd0);
    chk("rst_end_addr", {48'b0, end_addr_o}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].exp_err) begin
        poke_en = 1'b1;
        poke_addr = 16'h0011;
        poke_data = 40'h000000F806;
        @(negedge clk);
        poke_en = 1'b0;
      end
      run_session(vecs[i]);
    end

    // abort after three accepted bytes
    done0 = done_cnt;
    start_session(1'b0, 16'h0200);
    for (int k = 0; k < 3; k++) send_elem(8'(8'h40 + 8'(k)), 1'b0);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_busy", {63'b0, busy_o}, 64'd0);
    chk("abort_ready", {63'b0, s_ready_o}, 64'd0);
    chk("abort_words", {47'b0, words_o}, 64'd0);
    repeat (4) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - done0), 64'd0);

    // abort coinciding with the last element
    start_session(1'b0, 16'h0300);
    send_elem(8'h61, 1'b0);
    s_valid_i = 1'b1; s_data_i = 8'h62; s_last_i = 1'b1; abort_i = 1'b1;
    @(negedge clk);
    s_valid_i = 1'b0; s_last_i = 1'b0; abort_i = 1'b0;
    chk("abort_last_busy", {63'b0, busy_o}, 64'd0);
    repeat (4) @(negedge clk);
    chk("abort_last_no_done", 64'(done_cnt - done0), 64'd0);

    // asynchronous reset mid-word
    start_session(1'b0, 16'h0400);
    for (int k = 0; k < 3; k++) send_elem(8'(8'h70 + 8'(k)), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid_busy", {63'b0, busy_o}, 64'd0);
    chk("reset_mid_ready", {63'b0, s_ready_o}, 64'd0);
    chk("reset_mid_we", {63'b0, mem_we_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_wait_start", {63'b0, busy_o}, 64'd0);
    chk("reset_no_done", 64'(done_cnt - done0), 64'd0);

    // 20-bit lanes: two elements pack into one word
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    b_valid = 1'b1; b_data = 20'hABCDE; b_last = 1'b0;
    t = 0;
    while (!b_ready && t < 20) begin @(negedge clk); t++; end
    @(negedge clk);
    b_data = 20'h12345; b_last = 1'b1;
    t = 0;
    while (!b_ready && t < 20) begin @(negedge clk); t++; end
    @(negedge clk);
    b_valid = 1'b0; b_last = 1'b0;
    t = 0;
    while (!b_done && t < 20) begin @(negedge clk); t++; end
    chk("l20_done", {63'b0, b_done}, 64'd1);
    chk("l20_write_count", 64'(b_we_cnt), 64'd1);
    chk("l20_addr", {48'b0, b_we_addr}, 64'd0);
    chk("l20_data", {24'b0, b_we_data}, 64'h12345ABCDE);
    chk("l20_words", {47'b0, b_words}, 64'd1);
    chk("l20_end_addr", {48'b0, b_end}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required finish");
    $fatal(1);
  end

endmodule
